// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported, variable-latency memory between
// the fetch stage and the LSU. Each access uses a req/ack handshake to memory.
// The LSU normally has priority, and a loss counter guarantees that fetch
// still makes progress. An access that is never acked is aborted after
// TIMEOUT cycles.

module mem_port_arbiter #(
    parameter int STARVE_MAX = 4,    // fetch losses before fetch is forced to win (1..15)
    parameter int TIMEOUT    = 255   // cycles of unacked o_mem_req before abort (1..255)
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    // fetch requester
    input  logic        i_if_req,
    input  logic [31:0] i_if_addr,
    output logic [31:0] o_if_rdata,
    output logic        o_if_valid,
    output logic        o_if_stall,
    // load/store requester
    input  logic        i_ls_req,
    input  logic        i_ls_we,
    input  logic [3:0]  i_ls_be,
    input  logic [31:0] i_ls_addr,
    input  logic [31:0] i_ls_wdata,
    output logic [31:0] o_ls_rdata,
    output logic        o_ls_valid,
    output logic        o_ls_stall,
    // memory side
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic [3:0]  o_mem_be,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    input  logic        i_mem_ack,
    input  logic [31:0] i_mem_rdata,
    output logic        o_timeout_err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IF_BUSY = 2'd1,
        LS_BUSY = 2'd2
    } state_t;

    localparam logic [3:0] STARVE_LIM   = 4'(STARVE_MAX);
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    state_t      state_reg;
    logic [3:0]  starve_cnt_reg;
    logic [7:0]  timeout_cnt_reg;

    // Bit 0 is the fetch requester, bit 1 is the LSU.
    logic [1:0]  req_vec;
    logic [1:0]  valid_vec;
    logic [1:0]  pend_vec;

    logic        timeout_hit;
    logic        access_done;
    logic        arb_en;
    logic        elig_if;
    logic        elig_ls;
    logic        grant_if;
    logic        grant_ls;

    assign req_vec   = {i_ls_req, i_if_req};
    assign valid_vec = {o_ls_valid, o_if_valid};

    // A requester is pending while it holds req and has not yet seen its valid pulse.
    // During the valid cycle, req is still held, but it must not be granted again.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_pend
            assign pend_vec[gi] = req_vec[gi] & ~valid_vec[gi];
        end
    endgenerate

    assign o_if_stall = pend_vec[0];
    assign o_ls_stall = pend_vec[1];

    // Arbitration decision: it runs when idle and on the cycle an access completes.
    // The requester that is completing cannot win in its own completion cycle.
    always_comb begin
        timeout_hit = 1'b0;
        access_done = 1'b0;
        arb_en      = 1'b0;
        elig_if     = 1'b0;
        elig_ls     = 1'b0;
        grant_if    = 1'b0;
        grant_ls    = 1'b0;

        timeout_hit = o_mem_req & ~i_mem_ack & (timeout_cnt_reg == TIMEOUT_LAST);
        access_done = o_mem_req & (i_mem_ack | timeout_hit);
        arb_en      = (state_reg == IDLE) | access_done;
        elig_if     = pend_vec[0] & ~(access_done & (state_reg == IF_BUSY));
        elig_ls     = pend_vec[1] & ~(access_done & (state_reg == LS_BUSY));
        grant_if    = arb_en & elig_if & (~elig_ls | (starve_cnt_reg == STARVE_LIM));
        grant_ls    = arb_en & elig_ls & ~grant_if;
    end

    // Access sequencer. Memory request fields, completion pulses, read data,
    // and the starvation/timeout counters are all registered here.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg       <= IDLE;
            starve_cnt_reg  <= 4'd0;
            timeout_cnt_reg <= 8'd0;
            o_mem_req       <= 1'b0;
            o_mem_we        <= 1'b0;
            o_mem_be        <= 4'd0;
            o_mem_addr      <= 32'd0;
            o_mem_wdata     <= 32'd0;
            o_if_rdata      <= 32'd0;
            o_if_valid      <= 1'b0;
            o_ls_rdata      <= 32'd0;
            o_ls_valid      <= 1'b0;
            o_timeout_err   <= 1'b0;
        end else begin
            o_if_valid <= 1'b0;
            o_ls_valid <= 1'b0;

            // Completion: return data (zero on abort) and pulse valid next cycle.
            if (access_done) begin
                if (state_reg == IF_BUSY) begin
                    o_if_valid <= 1'b1;
                    o_if_rdata <= timeout_hit ? 32'd0 : i_mem_rdata;
                end
                if (state_reg == LS_BUSY) begin
                    o_ls_valid <= 1'b1;
                    o_ls_rdata <= timeout_hit ? 32'd0 : i_mem_rdata;
                end
            end

            if (timeout_hit) begin
                o_timeout_err <= 1'b1;
            end

            // Fetch loses only when it was eligible and the LSU won instead.
            if (grant_if) begin
                starve_cnt_reg <= 4'd0;
            end else if (grant_ls && elig_if && (starve_cnt_reg != STARVE_LIM)) begin
                starve_cnt_reg <= starve_cnt_reg + 4'd1;
            end

            if (grant_if || grant_ls) begin
                timeout_cnt_reg <= 8'd0;
            end else if (o_mem_req && !i_mem_ack) begin
                timeout_cnt_reg <= timeout_cnt_reg + 8'd1;
            end

            // A grant latches new fields. o_mem_req therefore stays high across
            // back-to-back accesses with no bubble.
            if (grant_if) begin
                state_reg   <= IF_BUSY;
                o_mem_req   <= 1'b1;
                o_mem_we    <= 1'b0;
                o_mem_be    <= 4'hF;
                o_mem_addr  <= i_if_addr;
                o_mem_wdata <= 32'd0;
            end else if (grant_ls) begin
                state_reg   <= LS_BUSY;
                o_mem_req   <= 1'b1;
                o_mem_we    <= i_ls_we;
                o_mem_be    <= i_ls_be;
                o_mem_addr  <= i_ls_addr;
                o_mem_wdata <= i_ls_wdata;
            end else if (access_done) begin
                state_reg   <= IDLE;
                o_mem_req   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: random requesters and a random memory responder.
// Each cycle, every DUT output is compared against a transaction-level
// reference model of the arbitration, timeout and completion rules.

module tb_mem_port_arbiter;

    localparam int STARVE_MAX = 4;
    localparam int TIMEOUT    = 255;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_if_req = 1'b0;
    logic [31:0] i_if_addr = 32'd0;
    logic [31:0] o_if_rdata;
    logic        o_if_valid;
    logic        o_if_stall;
    logic        i_ls_req = 1'b0;
    logic        i_ls_we = 1'b0;
    logic [3:0]  i_ls_be = 4'd0;
    logic [31:0] i_ls_addr = 32'd0;
    logic [31:0] i_ls_wdata = 32'd0;
    logic [31:0] o_ls_rdata;
    logic        o_ls_valid;
    logic        o_ls_stall;
    logic        o_mem_req;
    logic        o_mem_we;
    logic [3:0]  o_mem_be;
    logic [31:0] o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic        i_mem_ack = 1'b0;
    logic [31:0] i_mem_rdata = 32'd0;
    logic        o_timeout_err;

    mem_port_arbiter #(.STARVE_MAX(STARVE_MAX), .TIMEOUT(TIMEOUT)) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_if_req     (i_if_req),
        .i_if_addr    (i_if_addr),
        .o_if_rdata   (o_if_rdata),
        .o_if_valid   (o_if_valid),
        .o_if_stall   (o_if_stall),
        .i_ls_req     (i_ls_req),
        .i_ls_we      (i_ls_we),
        .i_ls_be      (i_ls_be),
        .i_ls_addr    (i_ls_addr),
        .i_ls_wdata   (i_ls_wdata),
        .o_ls_rdata   (o_ls_rdata),
        .o_ls_valid   (o_ls_valid),
        .o_ls_stall   (o_ls_stall),
        .o_mem_req    (o_mem_req),
        .o_mem_we     (o_mem_we),
        .o_mem_be     (o_mem_be),
        .o_mem_addr   (o_mem_addr),
        .o_mem_wdata  (o_mem_wdata),
        .i_mem_ack    (i_mem_ack),
        .i_mem_rdata  (i_mem_rdata),
        .o_timeout_err(o_timeout_err)
    );

    always #5 i_clk = ~i_clk;

    int n_vec = 0;
    int n_bad = 0;

    // Stimulus knobs
    int ack_pct    = 50;   // chance per cycle that memory acks
    int if_pct     = 70;   // chance a free fetch requester starts a new access
    int ls_pct     = 70;   // chance a free LSU requester starts a new access
    bit if_release = 1'b0; // completion seen, so fields may change this cycle
    bit ls_release = 1'b0;

    // Reference model: who owns memory (0 none, 1 fetch, 2 LSU) and the
    // values the outputs should show during the current cycle.
    int          m_owner;
    int          m_losses;
    int          m_wait;
    bit          m_err;
    bit          m_if_valid;
    bit          m_ls_valid;
    logic [31:0] m_if_rdata;
    logic [31:0] m_ls_rdata;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_be;
    bit          m_we;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner    = 0;
        m_losses   = 0;
        m_wait     = 0;
        m_err      = 1'b0;
        m_if_valid = 1'b0;
        m_ls_valid = 1'b0;
        m_if_rdata = 32'd0;
        m_ls_rdata = 32'd0;
        m_addr     = 32'd0;
        m_wdata    = 32'd0;
        m_be       = 4'd0;
        m_we       = 1'b0;
    endtask

    // Advance the model by one clock, using the inputs applied for this cycle.
    task automatic model_step();
        bit finishing, aborted, if_ok, ls_ok;
        int winner;
        finishing = (m_owner != 0) && (i_mem_ack || (m_wait == TIMEOUT - 1));
        aborted   = (m_owner != 0) && !i_mem_ack && (m_wait == TIMEOUT - 1);
        if_ok     = i_if_req && !m_if_valid && !(finishing && m_owner == 1);
        ls_ok     = i_ls_req && !m_ls_valid && !(finishing && m_owner == 2);
        winner    = 0;
        if (m_owner == 0 || finishing) begin
            if (if_ok && ls_ok) winner = (m_losses == STARVE_MAX) ? 1 : 2;
            else if (if_ok)     winner = 1;
            else if (ls_ok)     winner = 2;
        end
        m_if_valid = finishing && (m_owner == 1);
        m_ls_valid = finishing && (m_owner == 2);
        if (m_if_valid) m_if_rdata = aborted ? 32'd0 : i_mem_rdata;
        if (m_ls_valid) m_ls_rdata = aborted ? 32'd0 : i_mem_rdata;
        if (aborted) m_err = 1'b1;
        if (winner == 1) m_losses = 0;
        else if (winner == 2 && if_ok && m_losses < STARVE_MAX) m_losses++;
        if (winner != 0) m_wait = 0;
        else if (m_owner != 0 && !i_mem_ack) m_wait++;
        if (winner == 1) begin
            m_owner = 1; m_addr = i_if_addr; m_we = 1'b0; m_be = 4'hF;
        end else if (winner == 2) begin
            m_owner = 2; m_addr = i_ls_addr; m_we = i_ls_we; m_be = i_ls_be; m_wdata = i_ls_wdata;
        end else if (finishing) begin
            m_owner = 0;
        end
    endtask

    task automatic compare_outputs();
        check_eq("mem_req", 32'(o_mem_req), 32'(m_owner != 0));
        if (m_owner != 0) begin
            check_eq("mem_addr", o_mem_addr, m_addr);
            check_eq("mem_we", 32'(o_mem_we), 32'(m_we));
            check_eq("mem_be", 32'(o_mem_be), 32'(m_be));
            if (m_owner == 2) check_eq("mem_wdata", o_mem_wdata, m_wdata);
        end
        check_eq("if_valid", 32'(o_if_valid), 32'(m_if_valid));
        check_eq("ls_valid", 32'(o_ls_valid), 32'(m_ls_valid));
        check_eq("if_rdata", o_if_rdata, m_if_rdata);
        check_eq("ls_rdata", o_ls_rdata, m_ls_rdata);
        check_eq("timeout_err", 32'(o_timeout_err), 32'(m_err));
    endtask

    // Requesters follow the hold-until-valid rule. Memory acks at random.
    task automatic drive_inputs();
        if (!i_if_req || if_release) begin
            if_release = 1'b0;
            if ($urandom_range(99) < if_pct) begin
                i_if_req  = 1'b1;
                i_if_addr = $urandom & 32'hFFFF_FFFC;
            end else begin
                i_if_req  = 1'b0;
            end
        end else if (o_if_valid) begin
            if_release = 1'b1;
        end
        if (!i_ls_req || ls_release) begin
            ls_release = 1'b0;
            if ($urandom_range(99) < ls_pct) begin
                i_ls_req   = 1'b1;
                i_ls_we    = 1'($urandom_range(1));
                i_ls_be    = 4'($urandom_range(15));
                i_ls_addr  = $urandom;
                i_ls_wdata = $urandom;
            end else begin
                i_ls_req   = 1'b0;
            end
        end else if (o_ls_valid) begin
            ls_release = 1'b1;
        end
        i_mem_ack   = ($urandom_range(99) < ack_pct);
        i_mem_rdata = $urandom;
    endtask

    // One cycle: check outputs, apply new inputs, check stalls, advance model.
    task automatic step();
        @(negedge i_clk);
        compare_outputs();
        drive_inputs();
        #1;
        check_eq("if_stall", 32'(o_if_stall), 32'(i_if_req && !m_if_valid));
        check_eq("ls_stall", 32'(o_ls_stall), 32'(i_ls_req && !m_ls_valid));
        model_step();
    endtask

    task automatic run(input int cycles);
        for (int i = 0; i < cycles; i++) step();
    endtask

    initial begin
        model_reset();
        #2;
        check_eq("rst_mem_req", 32'(o_mem_req), 32'd0);
        check_eq("rst_if_valid", 32'(o_if_valid), 32'd0);
        check_eq("rst_ls_valid", 32'(o_ls_valid), 32'd0);
        check_eq("rst_timeout_err", 32'(o_timeout_err), 32'd0);
        check_eq("rst_if_rdata", o_if_rdata, 32'd0);
        check_eq("rst_ls_rdata", o_ls_rdata, 32'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;

        // Mixed traffic with random ack latency
        ack_pct = 50; if_pct = 70; ls_pct = 70;
        run(800);
        // Ack every cycle with both requesters busy: back-to-back accesses
        ack_pct = 100; if_pct = 100; ls_pct = 100;
        run(300);
        // Slow memory
        ack_pct = 15; if_pct = 60; ls_pct = 60;
        run(400);
        // Memory never answers, so accesses time out
        ack_pct = 0;
        run(600);
        // Normal operation resumes after aborts
        ack_pct = 60; if_pct = 70; ls_pct = 70;
        run(400);

        // Reset in the middle of an LSU access
        ack_pct = 0; if_pct = 0; ls_pct = 100;
        for (int i = 0; i < 100 && m_owner != 2; i++) step();
        check_eq("reach_ls_busy", 32'(m_owner), 32'd2);
        #2;
        i_rst_n = 1'b0;
        #1;
        check_eq("async_rst_mem_req", 32'(o_mem_req), 32'd0);
        check_eq("async_rst_ls_valid", 32'(o_ls_valid), 32'd0);
        check_eq("async_rst_if_valid", 32'(o_if_valid), 32'd0);
        check_eq("async_rst_timeout_err", 32'(o_timeout_err), 32'd0);
        model_reset();
        i_if_req = 1'b0; i_ls_req = 1'b0; i_mem_ack = 1'b0;
        if_release = 1'b0; ls_release = 1'b0;
        @(posedge i_clk);
        #2;
        i_rst_n = 1'b1;

        // No requests: idle acks must be ignored
        ack_pct = 100; if_pct = 0; ls_pct = 0;
        run(20);
        // Final mixed traffic
        ack_pct = 40; if_pct = 80; ls_pct = 50;
        run(600);
        if_pct = 0; ls_pct = 0; ack_pct = 100;
        run(20);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
